pwm_ramp_ctrl: RTL and testbench
================================

// Module: pwm_ramp_ctrl
// PURPOSE
//  Upstream driver for the pwm block: accepts a target duty (0-255) and slews the
//  applied ratio toward it in bounded steps, one pwm_update/pwm_done handshake per step.
//  Prevents motor current spikes from large duty jumps. Provides brake (immediate 0),
//  a handshake timeout fault, and status to the register/CPU interface.
// PARAMETERS
//  RAMP_STEP     1      duty increment per step (1..255)
//  INTERVAL_W    16     width of step-interval counter
//  DONE_TIMEOUT  512    cycles allowed from pwm_update rise to pwm_done before fault
// PORTS
//  clock         in   1   main clock
//  reset_n       in   1   asynchronous active-low reset
//  ramp_enable   in   1   allows new steps; low = hold current duty
//  target_ratio  in   8   requested duty out of 255
//  target_valid  in   1   1-cycle strobe: latch target_ratio
//  step_interval in   INTERVAL_W  idle cycles between acknowledged steps
//  brake         in   1   level: force target to 0 and jump there in one step
//  fault_clear   in   1   1-cycle strobe: leave FAULT
//  pwm_done      in   1   from pwm: update applied (1-cycle pulse)
//  pwm_ratio     out  8   to pwm: duty being requested
//  pwm_update    out  1   to pwm: request apply of pwm_ratio
//  pwm_enable    out  1   to pwm: ramp_enable & ~fault
//  current_ratio out  8   last duty acknowledged by pwm_done
//  at_target     out  1   current_ratio == latched target, state IDLE
//  busy          out  1   state != IDLE && state != FAULT
//  fault         out  1   handshake timeout occurred
// BEHAVIOUR
//  Reset: all outputs 0; latched target 0; state IDLE; counters 0. at_target=0 during reset, 1 first cycle after.
//  States: IDLE, REQUEST, INTERVAL, FAULT.
//  Target latch: target_valid loads target_ratio any state; brake overrides (target:=0), brake wins same cycle.
//  Next duty (registered on entry to REQUEST): cur<tgt -> min(cur+RAMP_STEP,tgt);
//   cur>tgt -> max(cur-RAMP_STEP,tgt); 9-bit arithmetic, saturating, never wraps. brake -> 0 directly.
//  IDLE: if ramp_enable && cur!=tgt -> REQUEST next cycle; else stay (at_target=1 when equal).
//  REQUEST: pwm_update=1, pwm_ratio held stable until pwm_done sampled 1;
//   on pwm_done: current_ratio:=pwm_ratio, pwm_update:=0 next cycle, -> INTERVAL.
//   Timeout counter counts from entry; reaching DONE_TIMEOUT without done: fault:=1,
//   pwm_update:=0, current_ratio unchanged -> FAULT. pwm_done outside REQUEST ignored.
//  INTERVAL: count step_interval cycles (0 = skip, go straight on); then -> IDLE evaluation
//   (min 1 cycle in IDLE). brake asserted: abort interval -> REQUEST with 0 if cur!=0.
//  ramp_enable low: in-flight REQUEST completes; no new REQUEST starts; pwm_enable=0.
//  Target change mid-ramp: takes effect at next step computation; direction may reverse.
//  FAULT: outputs held, pwm_enable=0; fault_clear -> IDLE, fault:=0. Only exit is fault_clear/reset.
//  Reset mid-REQUEST: pwm_update drops asynchronously; pwm block retains its own target.
// STRUCTURE
//  pwm_pkg: state encodings, RAMP_STEP/DONE_TIMEOUT defaults, DUTY_W=8 constant.
//  Sub-module ramp_timer: loadable down-counter shared for interval and timeout
//   (inputs load, value, en; output expired). FSM, step math, target latch stay top-level.
// TESTING (bench pairs DUT with pwm model, 256-cycle period)
//  Reset then target 0->40, STEP=8, interval=0 -> 5 handshakes, ratios 8,16,24,32,40; at_target=1.
//  From 40, target 37, STEP=8 -> single step to 37 (saturate, no undershoot/wrap).
//  Ramping up at 24 toward 200, brake asserted -> next request 0, target=0, then IDLE at_target.
//  pwm_done held 0 in REQUEST -> fault=1 at cycle DONE_TIMEOUT, pwm_update=0, pwm_enable=0;
//   fault_clear -> IDLE, then ramp resumes from unchanged current_ratio.
//  target 250, STEP=16, from 240 -> 250 (no overflow past 255); target 255 from 250 -> 255.
//  ramp_enable dropped mid-REQUEST -> handshake completes, no further steps; re-enable resumes.

Source files
------------

// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared types, defaults and step arithmetic for the pwm ramp controller.
package pwm_ramp_ctrl_pkg;

  localparam int unsigned DUTY_W           = 8;
  localparam int unsigned RAMP_STEP_DEF    = 1;
  localparam int unsigned INTERVAL_W_DEF   = 16;
  localparam int unsigned DONE_TIMEOUT_DEF = 512;

  typedef logic [DUTY_W-1:0] duty_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_INTERVAL,
    ST_FAULT
  } state_e;

  // Move cur one step toward tgt, clamping at tgt. Done in DUTY_W+1 bits so
  // neither cur+step nor tgt+step can wrap.
  function automatic duty_t step_toward(input duty_t cur, input duty_t tgt,
                                        input logic [DUTY_W:0] step);
    logic [DUTY_W:0] c_ext;
    logic [DUTY_W:0] t_ext;
    logic [DUTY_W:0] sum;
    logic [DUTY_W:0] lim;
    duty_t           res;
    c_ext = {1'b0, cur};
    t_ext = {1'b0, tgt};
    sum   = c_ext + step;
    lim   = t_ext + step;
    res   = tgt;
    if (c_ext < t_ext) begin
      if (sum < t_ext) res = sum[DUTY_W-1:0];
    end else if (c_ext > t_ext) begin
      if (c_ext > lim) res = cur - step[DUTY_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_ramp_ctrl_ramp_timer.sv
// Loadable down-counter; used for both the step interval and the handshake timeout.
module ramp_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load takes priority; otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Slews the duty requested from the pwm block toward a latched target, one
// pwm_update/pwm_done handshake per bounded step, with brake and timeout fault.
module pwm_ramp_ctrl
  import pwm_ramp_ctrl_pkg::*;
#(
  parameter int unsigned RAMP_STEP    = RAMP_STEP_DEF,
  parameter int unsigned INTERVAL_W   = INTERVAL_W_DEF,
  parameter int unsigned DONE_TIMEOUT = DONE_TIMEOUT_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ramp_enable_i,
  input  logic [DUTY_W-1:0]     target_ratio_i,
  input  logic                  target_valid_i,
  input  logic [INTERVAL_W-1:0] step_interval_i,
  input  logic                  brake_i,
  input  logic                  fault_clear_i,
  input  logic                  pwm_done_i,
  output logic [DUTY_W-1:0]     pwm_ratio_o,
  output logic                  pwm_update_o,
  output logic                  pwm_enable_o,
  output logic [DUTY_W-1:0]     current_ratio_o,
  output logic                  at_target_o,
  output logic                  busy_o,
  output logic                  fault_o
);

  localparam int unsigned TO_W = $clog2(DONE_TIMEOUT);
  localparam int unsigned TW   = (INTERVAL_W > TO_W) ? INTERVAL_W : TO_W;
  localparam logic [TW-1:0]     TO_LOAD = TW'(DONE_TIMEOUT - 1);
  localparam logic [DUTY_W:0]   STEP_X  = (DUTY_W + 1)'(RAMP_STEP);

  state_e  state_q, state_d;
  duty_t   target_q, target_d;
  duty_t   cur_q, cur_d;
  duty_t   ratio_q, ratio_d;
  logic    update_q, update_d;
  logic    fault_q, fault_d;
  logic    enable_q, enable_d;
  logic    at_tgt_q, at_tgt_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_value;
  logic          tmr_expired;

  ramp_timer #(
    .W(TW)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (tmr_load),
    .value_i  (tmr_value),
    .en_i     (1'b1),
    .expired_o(tmr_expired)
  );

  // Target latch, step computation and next-state/output logic.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    cur_d     = cur_q;
    ratio_d   = ratio_q;
    update_d  = update_q;
    fault_d   = fault_q;
    tmr_load  = 1'b0;
    tmr_value = '0;

    if (brake_i)             target_d = '0;
    else if (target_valid_i) target_d = target_ratio_i;

    unique case (state_q)
      ST_IDLE: begin
        // Brake jumps straight to 0 and is not held back by ramp_enable.
        if (brake_i && (cur_q != '0)) begin
          state_d   = ST_REQUEST;
          ratio_d   = '0;
          update_d  = 1'b1;
          tmr_load  = 1'b1;
          tmr_value = TO_LOAD;
        end else if (!brake_i && ramp_enable_i && (cur_q != target_q)) begin
          state_d   = ST_REQUEST;
          ratio_d   = step_toward(cur_q, target_q, STEP_X);
          update_d  = 1'b1;
          tmr_load  = 1'b1;
          tmr_value = TO_LOAD;
        end
      end
      ST_REQUEST: begin
        // A done arriving on the last timeout cycle still counts as success.
        if (pwm_done_i) begin
          cur_d    = ratio_q;
          update_d = 1'b0;
          if (step_interval_i == '0) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_INTERVAL;
            tmr_load  = 1'b1;
            tmr_value = TW'(step_interval_i) - TW'(1);
          end
        end else if (tmr_expired) begin
          fault_d  = 1'b1;
          update_d = 1'b0;
          state_d  = ST_FAULT;
        end
      end
      ST_INTERVAL: begin
        if (brake_i) begin
          if (cur_q != '0) begin
            state_d   = ST_REQUEST;
            ratio_d   = '0;
            update_d  = 1'b1;
            tmr_load  = 1'b1;
            tmr_value = TO_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (tmr_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (fault_clear_i) begin
          fault_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    enable_d = ramp_enable_i & ~fault_d;
    at_tgt_d = (state_d == ST_IDLE) && (cur_d == target_d);
  end

  // State and output registers; all outputs clear asynchronously on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      cur_q    <= '0;
      ratio_q  <= '0;
      update_q <= 1'b0;
      fault_q  <= 1'b0;
      enable_q <= 1'b0;
      at_tgt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cur_q    <= cur_d;
      ratio_q  <= ratio_d;
      update_q <= update_d;
      fault_q  <= fault_d;
      enable_q <= enable_d;
      at_tgt_q <= at_tgt_d;
    end
  end

  assign pwm_ratio_o     = ratio_q;
  assign pwm_update_o    = update_q;
  assign pwm_enable_o    = enable_q;
  assign current_ratio_o = cur_q;
  assign at_target_o     = at_tgt_q;
  assign fault_o         = fault_q;
  assign busy_o          = (state_q == ST_REQUEST) || (state_q == ST_INTERVAL);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: a pwm responder model acks each update, a monitor
// checks every handshake against a queue of expected step ratios and gaps.
module tb_pwm_ramp_ctrl;

  localparam int unsigned STEP = 8;
  localparam int unsigned IW   = 16;
  localparam int unsigned TO   = 512;
  localparam int unsigned LAT  = 2;

  logic          clk_i;
  logic          rst_ni;
  logic          ramp_enable_i;
  logic [7:0]    target_ratio_i;
  logic          target_valid_i;
  logic [IW-1:0] step_interval_i;
  logic          brake_i;
  logic          fault_clear_i;
  logic          pwm_done_i;
  logic [7:0]    pwm_ratio_o;
  logic          pwm_update_o;
  logic          pwm_enable_o;
  logic [7:0]    current_ratio_o;
  logic          at_target_o;
  logic          busy_o;
  logic          fault_o;

  pwm_ramp_ctrl #(
    .RAMP_STEP   (STEP),
    .INTERVAL_W  (IW),
    .DONE_TIMEOUT(TO)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .ramp_enable_i  (ramp_enable_i),
    .target_ratio_i (target_ratio_i),
    .target_valid_i (target_valid_i),
    .step_interval_i(step_interval_i),
    .brake_i        (brake_i),
    .fault_clear_i  (fault_clear_i),
    .pwm_done_i     (pwm_done_i),
    .pwm_ratio_o    (pwm_ratio_o),
    .pwm_update_o   (pwm_update_o),
    .pwm_enable_o   (pwm_enable_o),
    .current_ratio_o(current_ratio_o),
    .at_target_o    (at_target_o),
    .busy_o         (busy_o),
    .fault_o        (fault_o)
  );

  typedef struct {
    int unsigned ratio;
    int unsigned gap;   // 0 = do not check spacing
  } exp_t;

  exp_t        expq[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic        hold_done = 1'b0;
  logic        stray     = 1'b0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input int unsigned r, input int unsigned g);
    exp_t e;
    e.ratio = r;
    e.gap   = g;
    expq.push_back(e);
  endtask

  // Expected sequence of clamped steps from cur to tgt.
  task automatic push_ramp(input int unsigned cur, input int unsigned tgt);
    int unsigned v;
    v = cur;
    while (v != tgt) begin
      if (v < tgt) v = (v + STEP > tgt) ? tgt : v + STEP;
      else         v = (v < tgt + STEP) ? tgt : v - STEP;
      push(v, 0);
    end
  endtask

  task automatic set_target(input int unsigned t);
    @(negedge clk_i);
    target_ratio_i = 8'(t);
    target_valid_i = 1'b1;
    @(negedge clk_i);
    target_valid_i = 1'b0;
  endtask

  task automatic wait_at_target(input string name, input int unsigned budget);
    int unsigned n;
    n = 0;
    while (!at_target_o && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check(name, 32'(at_target_o), 1);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clk_i);
  endtask

  // pwm model: acknowledge each update LAT cycles after it is seen.
  initial begin
    int unsigned cnt;
    cnt = 0;
    pwm_done_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #2;
      pwm_done_i = 1'b0;
      if (stray) begin
        pwm_done_i = 1'b1;
      end else if (pwm_update_o && !hold_done) begin
        cnt++;
        if (cnt == LAT) begin
          pwm_done_i = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: every accepted handshake is checked against the scoreboard.
  initial begin
    int unsigned cyc;
    int unsigned last_hs;
    logic        chk_cur;
    int unsigned cur_exp;
    exp_t        e;
    cyc = 0;
    last_hs = 0;
    chk_cur = 1'b0;
    cur_exp = 0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (chk_cur) begin
        check("current_after_done", 32'(current_ratio_o), cur_exp);
        chk_cur = 1'b0;
      end
      if (rst_ni && pwm_update_o && pwm_done_i) begin
        if (expq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_handshake: got ratio %0d, expected none", pwm_ratio_o);
        end else begin
          e = expq.pop_front();
          check("pwm_ratio", 32'(pwm_ratio_o), e.ratio);
          if (e.gap != 0) check("step_gap", cyc - last_hs, e.gap);
          cur_exp = e.ratio;
          chk_cur = 1'b1;
        end
        last_hs = cyc;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    rst_ni          = 1'b0;
    ramp_enable_i   = 1'b1;
    target_ratio_i  = '0;
    target_valid_i  = 1'b0;
    step_interval_i = '0;
    brake_i         = 1'b0;
    fault_clear_i   = 1'b0;

    // Reset state
    idle(3);
    check("rst_update",    32'(pwm_update_o), 0);
    check("rst_ratio",     32'(pwm_ratio_o), 0);
    check("rst_enable",    32'(pwm_enable_o), 0);
    check("rst_at_target", 32'(at_target_o), 0);
    check("rst_busy",      32'(busy_o), 0);
    check("rst_fault",     32'(fault_o), 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post_rst_at_target", 32'(at_target_o), 1);
    check("post_rst_enable",    32'(pwm_enable_o), 1);

    // 0 -> 40, interval 0: five steps three cycles apart
    push(8, 0); push(16, 3); push(24, 3); push(32, 3); push(40, 3);
    set_target(40);
    wait_at_target("ramp40_at_target", 100);
    check("ramp40_current", 32'(current_ratio_o), 40);
    check("ramp40_busy", 32'(busy_o), 0);

    // 40 -> 37: single clamped step
    push(37, 0);
    set_target(37);
    wait_at_target("down37_at_target", 50);
    check("down37_current", 32'(current_ratio_o), 37);

    // interval 5: steps spaced interval+3 apart
    step_interval_i = 16'd5;
    push(29, 0); push(21, 8);
    set_target(21);
    wait_at_target("int5_at_target", 100);
    check("int5_current", 32'(current_ratio_o), 21);
    step_interval_i = '0;

    // down to 0
    push(13, 0); push(5, 3); push(0, 3);
    set_target(0);
    wait_at_target("zero_at_target", 100);
    check("zero_current", 32'(current_ratio_o), 0);

    // pwm_done outside REQUEST is ignored
    @(negedge clk_i);
    stray = 1'b1;
    @(negedge clk_i);
    stray = 1'b0;
    idle(3);
    check("stray_current", 32'(current_ratio_o), 0);
    check("stray_at_target", 32'(at_target_o), 1);

    // brake while ramping up at 24 toward 200
    step_interval_i = 16'd20;
    push(8, 0); push(16, 0); push(24, 0);
    set_target(200);
    n = 0;
    while (current_ratio_o != 8'd24 && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    check("brake_reached24", 32'(current_ratio_o), 24);
    push(0, 0);
    brake_i = 1'b1;
    idle(30);
    check("brake_current", 32'(current_ratio_o), 0);
    brake_i = 1'b0;
    step_interval_i = '0;
    idle(3);
    check("brake_at_target", 32'(at_target_o), 1);
    check("brake_busy", 32'(busy_o), 0);

    // handshake timeout -> FAULT
    hold_done = 1'b1;
    set_target(10);
    n = 0;
    while (!pwm_update_o && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    check("to_update_rise", 32'(pwm_update_o), 1);
    n = 0;
    while (!fault_o && n < TO + 50) begin
      @(negedge clk_i);
      n++;
    end
    check("to_fault", 32'(fault_o), 1);
    check("to_latency", n, TO);
    check("to_update_low", 32'(pwm_update_o), 0);
    check("to_enable_low", 32'(pwm_enable_o), 0);
    check("to_current", 32'(current_ratio_o), 0);
    check("to_busy", 32'(busy_o), 0);
    hold_done = 1'b0;
    idle(5);
    check("fault_held", 32'(fault_o), 1);
    push(8, 0); push(10, 0);
    fault_clear_i = 1'b1;
    @(negedge clk_i);
    fault_clear_i = 1'b0;
    check("clear_fault", 32'(fault_o), 0);
    wait_at_target("resume_at_target", 50);
    check("resume_current", 32'(current_ratio_o), 10);
    check("resume_enable", 32'(pwm_enable_o), 1);

    // top-end saturation
    push_ramp(10, 240);
    set_target(240);
    wait_at_target("up240_at_target", 300);
    push(248, 0); push(250, 0);
    set_target(250);
    wait_at_target("up250_at_target", 50);
    check("up250_current", 32'(current_ratio_o), 250);
    push(255, 0);
    set_target(255);
    wait_at_target("up255_at_target", 50);
    check("up255_current", 32'(current_ratio_o), 255);

    // ramp_enable dropped mid-REQUEST
    push(247, 0);
    set_target(200);
    n = 0;
    while (!pwm_update_o && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    check("en_update_rise", 32'(pwm_update_o), 1);
    ramp_enable_i = 1'b0;
    idle(15);
    check("en_current", 32'(current_ratio_o), 247);
    check("en_update", 32'(pwm_update_o), 0);
    check("en_enable", 32'(pwm_enable_o), 0);
    check("en_busy", 32'(busy_o), 0);
    check("en_at_target", 32'(at_target_o), 0);
    push(239, 0); push(231, 0); push(223, 0); push(215, 0); push(207, 0); push(200, 0);
    ramp_enable_i = 1'b1;
    wait_at_target("reen_at_target", 100);
    check("reen_current", 32'(current_ratio_o), 200);

    idle(3);
    check("queue_empty", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
